// File: rtl/arm_ex_pkg.sv
// Shared definitions for the ARM execute stage: opcodes, NZCV bit positions,
// multiply FSM states and small opcode classification helpers.
package arm_ex_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // TST/TEQ/CMP/CMN occupy 8..B: they always set flags and never write back
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_logical_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage bundled as one interface.
interface ex_stage_if;
  logic        reg_write_enable_in, mem_enable_in, mem_rw_in;
  logic        mem_to_reg_select_in, mem_size_in, pc_src_select_in;
  logic        alu_src_select_in;
  logic [3:0]  alu_control_in;
  logic        status_bit_in;
  logic [1:0]  am_bits_in;
  logic        is_mul_in;
  logic [31:0] reg_data_a_in, reg_data_b_in, reg_data_c_in;
  logic [31:0] extended_imm_in, pc_plus_4_in;
  logic [3:0]  reg_dst_in;
  logic        flush_in;

  logic        stall_out;
  logic [3:0]  flags_out;
  logic [31:0] alu_result_out, store_data_out, pc_plus_4_out;
  logic [3:0]  reg_dst_out;
  logic        reg_write_enable_out, mem_enable_out, mem_rw_out;
  logic        mem_to_reg_select_out, mem_size_out, pc_src_select_out;
  logic [1:0]  am_bits_out;

  modport master (
    output reg_write_enable_in, mem_enable_in, mem_rw_in, mem_to_reg_select_in,
           mem_size_in, pc_src_select_in, alu_src_select_in, alu_control_in,
           status_bit_in, am_bits_in, is_mul_in, reg_data_a_in, reg_data_b_in,
           reg_data_c_in, extended_imm_in, pc_plus_4_in, reg_dst_in, flush_in,
    input  stall_out, flags_out, alu_result_out, store_data_out, pc_plus_4_out,
           reg_dst_out, reg_write_enable_out, mem_enable_out, mem_rw_out,
           mem_to_reg_select_out, mem_size_out, pc_src_select_out, am_bits_out
  );

  modport slave (
    input  reg_write_enable_in, mem_enable_in, mem_rw_in, mem_to_reg_select_in,
           mem_size_in, pc_src_select_in, alu_src_select_in, alu_control_in,
           status_bit_in, am_bits_in, is_mul_in, reg_data_a_in, reg_data_b_in,
           reg_data_c_in, extended_imm_in, pc_plus_4_in, reg_dst_in, flush_in,
    output stall_out, flags_out, alu_result_out, store_data_out, pc_plus_4_out,
           reg_dst_out, reg_write_enable_out, mem_enable_out, mem_rw_out,
           mem_to_reg_select_out, mem_size_out, pc_src_select_out, am_bits_out
  );
endinterface

// File: rtl/arm_alu.sv
// Combinational ARM data-processing ALU: result plus raw NZCV for the opcode.
module arm_alu
  import arm_ex_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [31:0] x, y, logic_res;
  logic        cin, logical;
  logic [32:0] sum;

  // Subtracts become x + ~y + cin so one 33-bit adder yields C as NOT borrow
  always_comb begin
    x         = a;
    y         = b;
    cin       = 1'b0;
    logical   = 1'b0;
    logic_res = 32'd0;
    case (op)
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = carry_in;
      OP_SBC:         begin y = ~b; cin = carry_in; end
      OP_RSC:         begin x = b; y = ~a; cin = carry_in; end
      OP_AND, OP_TST: begin logical = 1'b1; logic_res = a & b; end
      OP_EOR, OP_TEQ: begin logical = 1'b1; logic_res = a ^ b; end
      OP_ORR:         begin logical = 1'b1; logic_res = a | b; end
      OP_MOV:         begin logical = 1'b1; logic_res = b; end
      OP_BIC:         begin logical = 1'b1; logic_res = a & ~b; end
      OP_MVN:         begin logical = 1'b1; logic_res = ~b; end
      default:        logical = 1'b0;
    endcase
  end

  assign sum    = {1'b0, x} + {1'b0, y} + {32'd0, cin};
  assign result = logical ? logic_res : sum[31:0];

  always_comb begin
    nzcv         = 4'd0;
    nzcv[FLAG_N] = result[31];
    nzcv[FLAG_Z] = (result == 32'd0);
    nzcv[FLAG_C] = sum[32];
    nzcv[FLAG_V] = (x[31] == y[31]) && (sum[31] != x[31]);
  end

endmodule

// File: rtl/ex_stage.sv
// ARM execute stage: ALU, NZCV register, EX/MEM register and, when MUL_EN is
// defined, a 32-cycle shift-add multiplier that stalls the front end.
module ex_stage
  import arm_ex_pkg::*;
(
  input  logic clk,
  input  logic reset,
  ex_stage_if.slave ex
);

  logic [31:0] operand_b, alu_result, mul_result;
  logic [3:0]  alu_nzcv, flags, flags_next;
  logic        test_op, write_flags, mul_busy, mul_done, stall;

  assign operand_b = ex.alu_src_select_in ? ex.extended_imm_in : ex.reg_data_b_in;

  arm_alu u_alu (
    .op       (alu_op_t'(ex.alu_control_in)),
    .a        (ex.reg_data_a_in),
    .b        (operand_b),
    .carry_in (flags[FLAG_C]),
    .result   (alu_result),
    .nzcv     (alu_nzcv)
  );

  assign test_op     = is_test_op(ex.alu_control_in);
  assign write_flags = test_op | ex.status_bit_in;

  // Logical ops have no meaningful carry/overflow, so C and V are kept
  always_comb begin
    flags_next = alu_nzcv;
    if (is_logical_op(ex.alu_control_in)) begin
      flags_next[FLAG_C] = flags[FLAG_C];
      flags_next[FLAG_V] = flags[FLAG_V];
    end
  end

`ifdef MUL_EN
  mul_state_t  state, next_state;
  logic [31:0] mcand, mplier, acc;
  logic [4:0]  count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ex.is_mul_in && !ex.flush_in) next_state = RUN;
      RUN:     if (ex.flush_in) next_state = IDLE;
               else if (count == 5'd31) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // DONE deliberately ignores is_mul_in, which is still held from ID/EX
  always_comb begin
    stall    = 1'b0;
    mul_done = 1'b0;
    if (!reset && !ex.flush_in) begin
      stall    = (state == RUN) || (state == IDLE && ex.is_mul_in);
      mul_done = (state == DONE);
    end
  end

  assign mul_busy   = stall;
  assign mul_result = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      count  <= 5'd0;
    end else if (state == IDLE && ex.is_mul_in && !ex.flush_in) begin
      mcand  <= ex.reg_data_a_in;
      mplier <= ex.reg_data_b_in;
      acc    <= 32'd0;
      count  <= 5'd0;
    end else if (state == RUN && !ex.flush_in) begin
      if (mcand[0]) acc <= acc + mplier;
      mcand  <= mcand >> 1;
      mplier <= mplier << 1;
      count  <= count + 5'd1;
    end
  end
`else
  assign stall      = 1'b0;
  assign mul_busy   = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = 32'd0;
`endif

  assign ex.stall_out = stall;
  assign ex.flags_out = flags;

  // Flush and multiply-busy cycles load a bubble: controls cleared, data held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags                    <= 4'd0;
      ex.alu_result_out        <= 32'd0;
      ex.store_data_out        <= 32'd0;
      ex.pc_plus_4_out         <= 32'd0;
      ex.reg_dst_out           <= 4'd0;
      ex.reg_write_enable_out  <= 1'b0;
      ex.mem_enable_out        <= 1'b0;
      ex.mem_rw_out            <= 1'b0;
      ex.mem_to_reg_select_out <= 1'b0;
      ex.mem_size_out          <= 1'b0;
      ex.pc_src_select_out     <= 1'b0;
      ex.am_bits_out           <= 2'd0;
    end else if (ex.flush_in || mul_busy) begin
      ex.reg_write_enable_out  <= 1'b0;
      ex.mem_enable_out        <= 1'b0;
      ex.mem_rw_out            <= 1'b0;
      ex.mem_to_reg_select_out <= 1'b0;
      ex.mem_size_out          <= 1'b0;
      ex.pc_src_select_out     <= 1'b0;
      ex.am_bits_out           <= 2'd0;
    end else begin
      ex.store_data_out        <= ex.reg_data_c_in;
      ex.pc_plus_4_out         <= ex.pc_plus_4_in;
      ex.reg_dst_out           <= ex.reg_dst_in;
      ex.mem_enable_out        <= ex.mem_enable_in;
      ex.mem_rw_out            <= ex.mem_rw_in;
      ex.mem_to_reg_select_out <= ex.mem_to_reg_select_in;
      ex.mem_size_out          <= ex.mem_size_in;
      ex.pc_src_select_out     <= ex.pc_src_select_in;
      ex.am_bits_out           <= ex.am_bits_in;
      if (mul_done) begin
        ex.alu_result_out       <= mul_result;
        ex.reg_write_enable_out <= ex.reg_write_enable_in;
        if (ex.status_bit_in) begin
          flags[FLAG_N] <= mul_result[31];
          flags[FLAG_Z] <= (mul_result == 32'd0);
        end
      end else begin
        ex.alu_result_out       <= alu_result;
        ex.reg_write_enable_out <= ex.reg_write_enable_in & ~test_op;
        if (write_flags) flags <= flags_next;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of ALU vectors plus flush, reset and
// (with MUL_EN) multiply sequences.
module tb_ex_stage;
  import arm_ex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic s, input logic src,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] res,
                              input logic [3:0] fl, input logic rw);
    vec_t v;
    v.op = op; v.s = s; v.src = src; v.a = a; v.b = b; v.imm = imm;
    v.exp_res = res; v.exp_flags = fl; v.exp_rw = rw;
    return v;
  endfunction

  function automatic logic [7:0] ctrlOut();
    return {bus.reg_write_enable_out, bus.mem_enable_out, bus.mem_rw_out,
            bus.mem_to_reg_select_out, bus.mem_size_out, bus.pc_src_select_out,
            bus.am_bits_out};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one ID/EX instruction on the falling edge
  task automatic applyStimulus(input logic [3:0] op, input logic s, input logic src,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic is_mul,
                               input logic flush, input logic [5:0] ctrl,
                               input logic [1:0] am, input logic [3:0] dst,
                               input logic [31:0] c, input logic [31:0] pc4);
    @(negedge clk);
    bus.alu_control_in       = op;
    bus.status_bit_in        = s;
    bus.alu_src_select_in    = src;
    bus.reg_data_a_in        = a;
    bus.reg_data_b_in        = b;
    bus.extended_imm_in      = imm;
    bus.is_mul_in            = is_mul;
    bus.flush_in             = flush;
    {bus.reg_write_enable_in, bus.mem_enable_in, bus.mem_rw_in,
     bus.mem_to_reg_select_in, bus.mem_size_in, bus.pc_src_select_in} = ctrl;
    bus.am_bits_in           = am;
    bus.reg_dst_in           = dst;
    bus.reg_data_c_in        = c;
    bus.pc_plus_4_in         = pc4;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_result"}, bus.alu_result_out, 32'd0);
    checkOutput({tag, "_store"}, bus.store_data_out, 32'd0);
    checkOutput({tag, "_pc4"}, bus.pc_plus_4_out, 32'd0);
    checkOutput({tag, "_ctrl"}, {24'd0, ctrlOut()}, 32'd0);
    checkOutput({tag, "_dst"}, {28'd0, bus.reg_dst_out}, 32'd0);
    checkOutput({tag, "_flags"}, {28'd0, bus.flags_out}, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, bus.stall_out}, 32'd0);
  endtask

`ifdef MUL_EN
  // Holds a MUL in ID/EX; stall must stay high 33 cycles, product lands on edge 34
  task automatic runMul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prod, input logic [3:0] exp_flags);
    applyStimulus(OP_MOV, 1'b1, 1'b0, a, b, 32'd0, 1'b1, 1'b0, 6'b100000, 2'b00,
                  4'd7, 32'h0, 32'h2000);
    for (int k = 1; k <= 34; k++) begin
      #1 checkOutput($sformatf("mul_stall_%0d", k), {31'd0, bus.stall_out},
                     {31'd0, (k <= 33)});
      @(posedge clk);
      #1;
      if (k <= 33)
        checkOutput($sformatf("mul_bubble_%0d", k), {24'd0, ctrlOut()}, 32'd0);
      @(negedge clk);
    end
    checkOutput("mul_result", bus.alu_result_out, prod);
    checkOutput("mul_rw", {31'd0, bus.reg_write_enable_out}, 32'd1);
    checkOutput("mul_flags", {28'd0, bus.flags_out}, {28'd0, exp_flags});
    applyStimulus(OP_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 6'b100000,
                  2'b00, 4'd1, 32'h0, 32'h0);
    #1 checkOutput("mul_after_stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1 checkOutput("mul_after_result", bus.alu_result_out, 32'd2);
  endtask
`endif

  initial begin
    reset = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 2'd0,
                  4'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 checkResetState("reset");
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back(mk(OP_ADD, 1, 0, 32'h7FFFFFFF, 32'h1,       0, 32'h80000000, 4'b1001, 1));
    vecs.push_back(mk(OP_CMP, 0, 0, 32'd5,        32'd5,       0, 32'h0,        4'b0110, 0));
    vecs.push_back(mk(OP_ADC, 1, 1, 32'hFFFFFFFF, 32'h55,      0, 32'h0,        4'b0110, 1));
    vecs.push_back(mk(OP_SUB, 0, 0, 32'd10,       32'd3,       0, 32'd7,        4'b0110, 1));
    vecs.push_back(mk(OP_SUB, 1, 0, 32'd3,        32'd10,      0, 32'hFFFFFFF9, 4'b1000, 1));
    vecs.push_back(mk(OP_ADD, 1, 0, 32'hFFFFFFFF, 32'd2,       0, 32'd1,        4'b0010, 1));
    vecs.push_back(mk(OP_AND, 1, 0, 32'hF0,       32'h0F,      0, 32'h0,        4'b0110, 1));
    vecs.push_back(mk(OP_SBC, 1, 0, 32'd10,       32'd3,       0, 32'd7,        4'b0010, 1));
    vecs.push_back(mk(OP_RSB, 1, 0, 32'd1,        32'h80000000,0, 32'h7FFFFFFF, 4'b0011, 1));
    vecs.push_back(mk(OP_RSC, 1, 0, 32'd0,        32'd5,       0, 32'd5,        4'b0010, 1));
    vecs.push_back(mk(OP_EOR, 0, 0, 32'hFF00FF00, 32'hFFFFFFFF,0, 32'h00FF00FF, 4'b0010, 1));
    vecs.push_back(mk(OP_TEQ, 0, 0, 32'hAAAA,     32'hAAAA,    0, 32'h0,        4'b0110, 0));
    vecs.push_back(mk(OP_TST, 0, 0, 32'h80000000, 32'hFFFFFFFF,0, 32'h80000000, 4'b1010, 0));
    vecs.push_back(mk(OP_CMN, 0, 0, 32'hFFFFFFFF, 32'd1,       0, 32'h0,        4'b0110, 0));
    vecs.push_back(mk(OP_MOV, 1, 1, 32'd0,        32'd0, 32'h12345678, 32'h12345678, 4'b0010, 1));
    vecs.push_back(mk(OP_MVN, 1, 0, 32'd0,        32'd0,       0, 32'hFFFFFFFF, 4'b1010, 1));
    vecs.push_back(mk(OP_BIC, 0, 0, 32'hFF,       32'h0F,      0, 32'hF0,       4'b1010, 1));
    vecs.push_back(mk(OP_ADC, 1, 0, 32'd1,        32'd1,       0, 32'd3,        4'b0000, 1));
    vecs.push_back(mk(OP_SBC, 1, 0, 32'd5,        32'd5,       0, 32'hFFFFFFFF, 4'b1000, 1));
    vecs.push_back(mk(OP_CMP, 0, 0, 32'h80000000, 32'd1,       0, 32'h7FFFFFFF, 4'b0011, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [4:0] pat;
      pat = 5'(i + 1);
      applyStimulus(vecs[i].op, vecs[i].s, vecs[i].src, vecs[i].a, vecs[i].b,
                    vecs[i].imm, 1'b0, 1'b0, {1'b1, pat}, pat[1:0], pat[3:0],
                    32'hC0000000 + 32'(i), 32'h1000 + 32'(4 * i));
      #1 checkOutput($sformatf("v%0d_stall", i), {31'd0, bus.stall_out}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_result", i), bus.alu_result_out, vecs[i].exp_res);
      checkOutput($sformatf("v%0d_flags", i), {28'd0, bus.flags_out}, {28'd0, vecs[i].exp_flags});
      checkOutput($sformatf("v%0d_ctrl", i), {24'd0, ctrlOut()},
                  {24'd0, vecs[i].exp_rw, pat, pat[1:0]});
      checkOutput($sformatf("v%0d_dst", i), {28'd0, bus.reg_dst_out}, {28'd0, pat[3:0]});
      checkOutput($sformatf("v%0d_store", i), bus.store_data_out, 32'hC0000000 + 32'(i));
      checkOutput($sformatf("v%0d_pc4", i), bus.pc_plus_4_out, 32'h1000 + 32'(4 * i));
    end

    // Flush: bubble, flags held even though S=1
    applyStimulus(OP_ADD, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 6'b111111,
                  2'b11, 4'hF, 32'h0, 32'h0);
    #1 checkOutput("flush_stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush_ctrl", {24'd0, ctrlOut()}, 32'd0);
    checkOutput("flush_flags", {28'd0, bus.flags_out}, 32'h3);

`ifndef MUL_EN
    // Without the multiplier, is_mul_in is ignored and the opcode executes
    applyStimulus(OP_ADD, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 1'b1, 1'b0, 6'b100000,
                  2'b00, 4'd2, 32'h0, 32'h0);
    #1 checkOutput("nomul_stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("nomul_result", bus.alu_result_out, 32'd5);
    checkOutput("nomul_rw", {31'd0, bus.reg_write_enable_out}, 32'd1);
`else
    // Flags are 0011 here: MUL S=1 sets N,Z from the product and keeps C,V
    runMul(32'h1234, 32'h10, 32'h12340, 4'b0011);

    // Flush during RUN after ten multiply steps
    applyStimulus(OP_MOV, 1'b1, 1'b0, 32'h1234, 32'h10, 32'd0, 1'b1, 1'b0, 6'b100000,
                  2'b00, 4'd7, 32'h0, 32'h0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.flush_in = 1'b1;
    #1 checkOutput("mflush_stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mflush_ctrl", {24'd0, ctrlOut()}, 32'd0);
    checkOutput("mflush_flags", {28'd0, bus.flags_out}, 32'h3);
    applyStimulus(OP_ADD, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0, 1'b0, 1'b0, 6'b100000,
                  2'b00, 4'd3, 32'h0, 32'h0);
    #1 checkOutput("mflush_idle_stall", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mflush_next_result", bus.alu_result_out, 32'd42);
    checkOutput("mflush_next_rw", {31'd0, bus.reg_write_enable_out}, 32'd1);

    // Reset partway through RUN, then a full multiply from a clean start
    applyStimulus(OP_MOV, 1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 1'b1, 1'b0, 6'b100000,
                  2'b00, 4'd7, 32'h0, 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetState("mreset");
    @(negedge clk);
    bus.is_mul_in = 1'b0;
    reset = 1'b0;
    runMul(32'd7, 32'd6, 32'd42, 4'b0000);
`endif

    // Asynchronous reset away from any clock edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetState("areset");
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
